pp_pipeline_accel_fifo_to_axis: RTL and testbench
=================================================

Name: pp_pipeline_accel_fifo_to_axis

Overview:
- Read-side consumer for the pipeline's ap_fifo-style FIFOs (full_n/write producer side, empty_n/read consumer side).
- Drains exactly one frame of img_rows × img_cols words from the FIFO read port and emits them as an AXI4-Stream master.
- Frame markers: TUSER on the first pixel of the frame, TLAST on the last pixel of each line.
- Sits at the accelerator output, between the last internal FIFO and the DMA/VDMA stream.

Parameters:
- DATA_WIDTH, 16, width of FIFO words and TDATA.
- DIM_WIDTH, 12, width of the row/column dimension inputs; max dimension is 2^DIM_WIDTH-1, so 3840 fits.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to transfer one frame; honoured only when idle.
- img_rows  in  DIM_WIDTH  frame height; sampled on an accepted start.
- img_cols  in  DIM_WIDTH  frame width; sampled on an accepted start.
- busy  out  1  high from an accepted start until completion.
- done  out  1  one-cycle completion pulse.
- if_empty_n  in  1  FIFO has valid if_dout.
- if_read_ce  out  1  FIFO read clock enable; tied to 1.
- if_read  out  1  FIFO pop.
- if_dout  in  DATA_WIDTH  FIFO head data; valid when if_empty_n=1.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  end of line.
- m_axis_tuser  out  1  start of frame.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: busy=0, done=0, if_read=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0; FSM=IDLE; counters=0; buffer empty.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with both dimensions nonzero → latch rows/cols, clear rd_col/rd_row, go to RUN; busy=1 from the next cycle.
  - start=1 with either dimension zero → done=1 next cycle, stay in IDLE, no FIFO reads.
- RUN:
  - if_read = if_empty_n & (buf_count<2). Combinational from registered buf_count and if_empty_n only; no combinational path from m_axis_tready.
  - Each pop writes {if_dout, tlast=(rd_col==cols-1), tuser=(rd_row==0 && rd_col==0)} into a 2-entry buffer in the same cycle.
  - rd_col increments on each pop and wraps to 0 at cols-1, incrementing rd_row at the wrap.
  - The pop with rd_row==rows-1 && rd_col==cols-1 is the last read; go to DRAIN. No further if_read in this frame.
- DRAIN: when the buffer becomes empty (last beat handshaken), done=1 the next cycle together with busy=0, then return to IDLE.
- Buffer (FIFO order, 2 entries):
  - m_axis_tvalid=(buf_count>0); TDATA/TLAST/TUSER come from the head entry.
  - Handshake = tvalid & tready.
  - Simultaneous push and pop leaves buf_count unchanged.
  - With tready held high and the FIFO non-empty, throughput is one beat per cycle.
  - Read-to-stream latency is 1 cycle: data is popped in cycle N and is on TDATA in cycle N+1.
- AXI rules:
  - Once tvalid=1, TDATA/TLAST/TUSER are held stable until the handshake.
  - tvalid never drops without a handshake.
- Width: TLAST/TUSER comparisons use DIM_WIDTH counters. Frame pixel count is never formed; no wider arithmetic is needed.
- start while busy is ignored; latched dimensions are unaffected.
- Words beyond the frame are left in the FIFO untouched.
- Reset mid-frame: buffered words are discarded and the FSM returns to IDLE. The FIFO is not flushed by this block.

Decomposition:
- Package pp_pipeline_accel_fifo_to_axis_pkg holds:
  - the FSM state encoding (IDLE/RUN/DRAIN);
  - the buffer entry layout {tuser, tlast, data};
  - the localparam BUF_DEPTH=2.
- Sub-module pp_pipeline_accel_axis_skid2: 2-entry register buffer with push/pop/count; the parent holds the FSM and counters.

Test Plan:
- rows=2, cols=4, FIFO preloaded 0x0001..0x0008, tready=1 → 8 consecutive beats 0x0001..0x0008; TUSER only on beat 1; TLAST on beats 4 and 8; done 1 cycle after beat 8; busy=0 thereafter.
- Same frame, tready pattern 1,0,0,1,0,1… → order preserved, no duplicates or drops; if_read never high while buf_count=2; TDATA stable while stalled.
- FIFO empty_n toggling randomly, rows=3, cols=5 → 15 beats in order; tvalid gaps allowed; TLAST on beats 5, 10 and 15.
- FIFO holds 10 words, rows=1, cols=8 → exactly 8 pops; 2 words remain (if_empty_n still 1); no if_read after the 8th pop.
- start with img_cols=0 → done pulse next cycle, zero if_read, tvalid stays 0; a second start during an active frame is ignored.
- reset after 3 beats of a 2×4 frame, then start rows=1, cols=3 → outputs at reset values; new frame emits 3 beats with TUSER on its first beat and TLAST on its third beat.

Source files
------------

// File: rtl/pp_pipeline_accel_fifo_to_axis_pkg.sv
// rtl/pp_pipeline_accel_fifo_to_axis_pkg.sv - shared types for the FIFO-to-AXI-Stream frame drainer
package pp_pipeline_accel_fifo_to_axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Buffer entries are stored as {tuser, tlast, data}; the flags form the upper bits.
  typedef struct packed {
    logic tuser;
    logic tlast;
  } beat_flags_t;

  localparam int BUF_DEPTH  = 2;
  localparam int FLAG_WIDTH = $bits(beat_flags_t);

endpackage

// File: rtl/pp_pipeline_accel_axis_skid2.sv
// rtl/pp_pipeline_accel_axis_skid2.sv - two-entry register FIFO holding outgoing stream beats
module pp_pipeline_accel_axis_skid2
  import pp_pipeline_accel_fifo_to_axis_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic             do_pop;
  logic             do_push;

  assign do_pop    = pop && (count != 2'd0);
  assign do_push   = push && ((count != FULL) || do_pop);
  assign head_data = entry0;

  always_ff @(posedge clk) begin
    if (reset) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        2'b10: begin
          if (count == 2'd0) entry0 <= push_data;
          else               entry1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pp_pipeline_accel_fifo_to_axis.sv
// rtl/pp_pipeline_accel_fifo_to_axis.sv - drains one frame from an ap_fifo read port onto an AXI4-Stream master
module pp_pipeline_accel_fifo_to_axis
  import pp_pipeline_accel_fifo_to_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIM_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  img_rows,
  input  logic [DIM_WIDTH-1:0]  img_cols,
  output logic                  busy,
  output logic                  done,
  input  logic                  if_empty_n,
  output logic                  if_read_ce,
  output logic                  if_read,
  input  logic [DATA_WIDTH-1:0] if_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);

  localparam int ENTRY_WIDTH = DATA_WIDTH + FLAG_WIDTH;
  localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);

  state_t                 state;
  logic [DIM_WIDTH-1:0]   rows;
  logic [DIM_WIDTH-1:0]   cols;
  logic [DIM_WIDTH-1:0]   rd_row;
  logic [DIM_WIDTH-1:0]   rd_col;
  logic [1:0]             buf_count;
  logic [ENTRY_WIDTH-1:0] push_entry;
  logic [ENTRY_WIDTH-1:0] head_entry;
  beat_flags_t            push_flags;
  beat_flags_t            head_flags;
  logic                   col_last;
  logic                   row_last;
  logic                   handshake;

  assign if_read_ce = 1'b1;
  // Read decision depends only on registered occupancy, never on tready.
  assign if_read    = (state == ST_RUN) && if_empty_n && (buf_count < 2'(BUF_DEPTH));

  assign col_last         = (rd_col == cols - ONE);
  assign row_last         = (rd_row == rows - ONE);
  assign push_flags.tuser = (rd_row == '0) && (rd_col == '0);
  assign push_flags.tlast = col_last;
  assign push_entry       = {push_flags, if_dout};

  assign handshake     = m_axis_tvalid && m_axis_tready;
  assign head_flags    = beat_flags_t'(head_entry[ENTRY_WIDTH-1:DATA_WIDTH]);
  assign m_axis_tdata  = head_entry[DATA_WIDTH-1:0];
  assign m_axis_tlast  = head_flags.tlast;
  assign m_axis_tuser  = head_flags.tuser;
  assign m_axis_tvalid = (buf_count != 2'd0);

  pp_pipeline_accel_axis_skid2 #(
    .WIDTH (ENTRY_WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (if_read),
    .push_data (push_entry),
    .pop       (handshake),
    .head_data (head_entry),
    .count     (buf_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      rows   <= '0;
      cols   <= '0;
      rd_row <= '0;
      rd_col <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if ((img_rows != '0) && (img_cols != '0)) begin
              rows   <= img_rows;
              cols   <= img_cols;
              rd_row <= '0;
              rd_col <= '0;
              busy   <= 1'b1;
              state  <= ST_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (if_read) begin
            if (col_last) begin
              rd_col <= '0;
              rd_row <= rd_row + ONE;
              if (row_last) state <= ST_DRAIN;
            end else begin
              rd_col <= rd_col + ONE;
            end
          end
        end
        ST_DRAIN: begin
          // Finish as soon as the final beat leaves the buffer.
          if ((buf_count == 2'd0) || ((buf_count == 2'd1) && handshake)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_to_axis.sv
// tb/tb_pp_pipeline_accel_fifo_to_axis.sv - directed self-checking bench for the frame drainer
module tb_pp_pipeline_accel_fifo_to_axis;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] img_rows;
  logic [11:0] img_cols;
  logic        busy;
  logic        done;
  logic        if_empty_n;
  logic        if_read_ce;
  logic        if_read;
  logic [15:0] if_dout;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;

  pp_pipeline_accel_fifo_to_axis #(.DATA_WIDTH(16), .DIM_WIDTH(12)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .img_rows      (img_rows),
    .img_cols      (img_cols),
    .busy          (busy),
    .done          (done),
    .if_empty_n    (if_empty_n),
    .if_read_ce    (if_read_ce),
    .if_read       (if_read),
    .if_dout       (if_dout),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] fq[$];
  logic [15:0] expq[$];
  logic [15:0] bd[$];
  bit          bl[$];
  bit          bu[$];
  int          bc[$];
  bit          pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  bit          gate_rand = 0;
  int          tr_mode = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          reads, done_cnt, done_cyc, outstanding, stall_viol, rdfull_viol;
  bit          prev_stall;
  logic [15:0] prev_d;
  bit          prev_l, prev_u;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    bd.delete(); bl.delete(); bu.delete(); bc.delete();
    reads = 0; done_cnt = 0; done_cyc = -1;
    stall_viol = 0; rdfull_viol = 0; prev_stall = 0;
  endtask

  task automatic load(input int n, input logic [15:0] base);
    expq.delete();
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + 16'(i));
      expq.push_back(base + 16'(i));
    end
  endtask

  // One clock: drive at negedge, snapshot just before posedge, apply FIFO pop after it.
  task automatic tick();
    bit rd, hs;
    m_axis_tready = (tr_mode == 0) ? 1'b1 : pat[cyc % 6];
    if_empty_n = (fq.size() > 0) && (gate_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    if_dout = (fq.size() > 0) ? fq[0] : 16'h0;
    #1;
    rd = if_read;
    hs = m_axis_tvalid && m_axis_tready;
    if (rd && outstanding >= 2) rdfull_viol++;
    if (prev_stall && (!m_axis_tvalid || m_axis_tdata != prev_d ||
                       m_axis_tlast != prev_l || m_axis_tuser != prev_u)) stall_viol++;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_d = m_axis_tdata; prev_l = m_axis_tlast; prev_u = m_axis_tuser;
    if (hs) begin
      bd.push_back(m_axis_tdata); bl.push_back(m_axis_tlast);
      bu.push_back(m_axis_tuser); bc.push_back(cyc);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    @(negedge clk);
    if (rd && fq.size() > 0) begin void'(fq.pop_front()); reads++; end
    outstanding += int'(rd) - int'(hs);
    cyc++;
  endtask

  task automatic start_frame(input int r, input int c);
    img_rows = 12'(r); img_cols = 12'(c); start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    chk({tag, "_timeout"}, done_cnt, 1);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic verify_frame(input string tag, input int rows, input int cols);
    chk({tag, "_beats"}, bd.size(), rows * cols);
    for (int i = 0; i < bd.size() && i < expq.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), bd[i], expq[i]);
      chk($sformatf("%s_last%0d", tag, i), bl[i], ((i % cols) == cols - 1));
      chk($sformatf("%s_user%0d", tag, i), bu[i], (i == 0));
    end
    chk({tag, "_stable"}, stall_viol, 0);
    chk({tag, "_rd_full"}, rdfull_viol, 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
    chk({tag, "_tlast"}, m_axis_tlast, 0);
    chk({tag, "_tuser"}, m_axis_tuser, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_if_read"}, if_read, 0);
    chk({tag, "_read_ce"}, if_read_ce, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; img_rows = '0; img_cols = '0;
    if_empty_n = 1'b0; if_dout = '0; m_axis_tready = 1'b1;
    outstanding = 0;
    clear_log();
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    outstanding = 0;
    check_idle("reset");

    // Frame 2x4, tready high: back-to-back beats, exact latency
    clear_log(); load(8, 16'h0001);
    start_frame(2, 4);
    wait_done("t1", 60);
    verify_frame("t1", 2, 4);
    if (bc.size() == 8) begin
      chk("t1_first_lat", bc[0] - start_cyc, 2);
      chk("t1_back2back", bc[7] - bc[0], 7);
      chk("t1_done_lat", done_cyc - bc[7], 1);
    end
    tick();
    chk("t1_done_once", done_cnt, 1);

    // Same frame with stalled tready pattern
    clear_log(); load(8, 16'h0001); tr_mode = 1;
    start_frame(2, 4);
    wait_done("t2", 100);
    verify_frame("t2", 2, 4);
    tr_mode = 0;

    // Random empty_n, 3x5
    clear_log(); load(15, 16'h0101); gate_rand = 1;
    start_frame(3, 5);
    wait_done("t3", 300);
    verify_frame("t3", 3, 5);
    gate_rand = 0;

    // FIFO holds 10 words, frame takes 8
    clear_log(); load(10, 16'h0201);
    start_frame(1, 8);
    wait_done("t4", 60);
    expq = expq[0:7];
    verify_frame("t4", 1, 8);
    tick(); tick();
    chk("t4_reads", reads, 8);
    chk("t4_left", fq.size(), 2);
    chk("t4_empty_n", if_empty_n, 1);
    fq.delete();

    // Zero dimension: immediate done, no reads
    clear_log(); load(2, 16'h0301);
    start_frame(3, 0);
    tick();
    chk("t5_done", done_cnt, 1);
    chk("t5_done_lat", done_cyc - start_cyc, 1);
    tick(); tick();
    chk("t5_reads", reads, 0);
    chk("t5_beats", bd.size(), 0);
    chk("t5_busy", busy, 0);
    fq.delete();

    // Second start during an active frame is ignored
    clear_log(); load(8, 16'h0401);
    start_frame(2, 4);
    tick(); tick(); tick();
    img_rows = 12'd1; img_cols = 12'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5b_busy", busy, 1);
    wait_done("t5b", 60);
    verify_frame("t5b", 2, 4);

    // Reset mid-frame, then a fresh 1x3 frame
    clear_log(); load(8, 16'h0501);
    start_frame(2, 4);
    for (int n = 0; n < 20 && bd.size() < 3; n++) tick();
    chk("t6_pre_beats", bd.size(), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    outstanding = 0;
    check_idle("t6_rst");
    fq.delete();
    clear_log(); load(3, 16'h00A1);
    start_frame(1, 3);
    wait_done("t6", 40);
    verify_frame("t6", 1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
